// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline sequencer and its hazard comparator.
package pipe_ctrl_pkg;

    localparam int REG_W_DEF   = 3;
    localparam int STALL_CNT_W = 16;
    localparam int LAT_CNT_W   = 4;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        HALT      = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use register-match comparator; kept standalone so forwarding logic can reuse it.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] i_src1,
    input  logic [REG_W-1:0] i_src2,
    input  logic             i_use1,
    input  logic             i_use2,
    input  logic             i_is_load,
    input  logic [REG_W-1:0] i_rd,
    output logic             o_haz
);

    logic w_match1;
    logic w_match2;

    // Register 0 is an ordinary register here, so no zero-index exclusion.
    assign w_match1 = i_use1 && (i_src1 == i_rd);
    assign w_match2 = i_use2 && (i_src2 == i_rd);
    assign o_haz    = i_is_load && (w_match1 || w_match2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: load-use stalls, jump redirect, HALT/resume and a
// saturating stall-cycle counter for the fetch/decode/execute core.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RUN       | normal issue; jump > hazard > halt priority
// LOAD_WAIT | holding decode until the load result is available
// HALT      | frozen until a resume pulse
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int A_SIZE  = 10,
    parameter int REG_W   = REG_W_DEF,
    parameter int MEM_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_W-1:0]       dec_src1,
    input  logic [REG_W-1:0]       dec_src2,
    input  logic                   dec_use1,
    input  logic                   dec_use2,
    input  logic                   dec_halt,
    input  logic                   ex_is_load,
    input  logic [REG_W-1:0]       ex_rd,
    input  logic                   jmp_taken,
    input  logic [A_SIZE-1:0]      jmp_target,
    input  logic                   resume,
    output logic                   stall,
    output logic                   load_pc_flag,
    output logic [A_SIZE-1:0]      load_pc,
    output logic                   bubble,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] perf_stall_cnt
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD  = LAT_CNT_W'(MEM_LAT - 1);
    localparam bit                   LAT_MULTI = (MEM_LAT > 1);

    pc_state_t              r_state;
    pc_state_t              w_state_nxt;
    logic [LAT_CNT_W-1:0]   r_lat_cnt;
    logic [LAT_CNT_W-1:0]   w_lat_cnt_nxt;
    logic                   r_halted;
    logic [STALL_CNT_W-1:0] r_perf_cnt;
    logic                   w_haz;
    logic                   w_stall;
    logic                   w_flag;
    logic                   w_bubble;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .i_src1    (dec_src1),
        .i_src2    (dec_src2),
        .i_use1    (dec_use1),
        .i_use2    (dec_use2),
        .i_is_load (ex_is_load),
        .i_rd      (ex_rd),
        .o_haz     (w_haz)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_stall       = 1'b0;
        w_flag        = 1'b0;
        w_bubble      = 1'b0;
        case (r_state)
            RUN: begin
                // A taken jump squashes the younger instruction, so its hazard or halt is moot.
                if (jmp_taken) begin
                    w_flag   = 1'b1;
                    w_bubble = 1'b1;
                end else if (w_haz) begin
                    w_stall       = 1'b1;
                    w_bubble      = 1'b1;
                    w_lat_cnt_nxt = LAT_LOAD;
                    w_state_nxt   = LAT_MULTI ? LOAD_WAIT : RUN;
                end else if (dec_halt) begin
                    w_stall     = 1'b1;
                    w_bubble    = 1'b1;
                    w_state_nxt = HALT;
                end
            end
            LOAD_WAIT: begin
                if (jmp_taken) begin
                    w_flag        = 1'b1;
                    w_bubble      = 1'b1;
                    w_lat_cnt_nxt = '0;
                    w_state_nxt   = RUN;
                end else begin
                    w_stall       = 1'b1;
                    w_bubble      = 1'b1;
                    w_lat_cnt_nxt = r_lat_cnt - 1'b1;
                    if (r_lat_cnt <= LAT_CNT_W'(1)) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            HALT: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
                if (resume) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt   = RUN;
                w_lat_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_lat_cnt  <= '0;
            r_halted   <= 1'b0;
            r_perf_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            r_halted  <= (w_state_nxt == HALT);
            if (w_stall && (r_perf_cnt != {STALL_CNT_W{1'b1}})) begin
                r_perf_cnt <= r_perf_cnt + 1'b1;
            end
        end
    end

    // Fetch/decode must see idle controls the moment reset asserts.
    assign stall          = reset && w_stall;
    assign load_pc_flag   = reset && w_flag;
    assign bubble         = reset && w_bubble;
    assign load_pc        = load_pc_flag ? jmp_target : '0;
    assign halted         = r_halted;
    assign perf_stall_cnt = r_perf_cnt;

endmodule
